dmem_arbiter: RTL

Two-port round-robin arbiter and access sequencer for the 256-byte data memory (`DataMemory`). It sits between two word-access requesters (CPU load/store unit on port 0, debug/DMA loader on port 1) and the memory's level-sensitive `MemRead`/`MemWrite` interface. It grants one request at a time and checks address legality. For legal requests it drives a single-cycle memory strobe from registered address and data, captures read data, and returns a one-cycle acknowledge.

---
 rtl/dmem_arb_pkg.sv | 27 ++
 rtl/dmem_rr_pick2.sv | 19 +
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types, constants and the address-legality helper for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam int unsigned WORD_BYTES        = 4;
    localparam int unsigned DEFAULT_MEM_BYTES = 256;

    // The upper-byte test is fixed at bit 8 because DataMemory decodes only 8 address bits.
    function automatic logic addr_legal(
        input logic [31:0] addr,
        input logic [31:0] mem_bytes,
        input logic        align_check
    );
        logic ok;
        ok = (addr[31:8] == 24'd0) && (addr <= (mem_bytes - 32'(WORD_BYTES)));
        if (align_check && (addr[1:0] != 2'b00)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/dmem_rr_pick2.sv
// Two-requester round-robin pick: a lone request wins, a tie goes to the port not granted last.
module dmem_rr_pick2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic grant_valid_o,
    output logic grant_id_o
);

    always_comb begin
        grant_valid_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            grant_id_o = ~last_i;
        end else begin
            grant_id_o = req1_i;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and single-cycle access sequencer for the 256-byte data memory.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MEM_BYTES   = DEFAULT_MEM_BYTES,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_read,
    output logic        mem_write
);

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic        id_q, id_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        grant_valid;
    logic        grant_id;
    logic [31:0] sel_addr;

    dmem_rr_pick2 u_pick (
        .req0_i        (req0),
        .req1_i        (req1),
        .last_i        (last_q),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    assign sel_addr = grant_id ? addr1 : addr0;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        we_d    = we_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    id_d    = grant_id;
                    we_d    = grant_id ? we1 : we0;
                    addr_d  = sel_addr;
                    wdata_d = grant_id ? wdata1 : wdata0;
                    if (addr_legal(sel_addr, 32'(MEM_BYTES), ALIGN_CHECK)) begin
                        err_d   = 1'b0;
                        state_d = ACCESS;
                    end else begin
                        // Rejected requests skip the memory entirely and answer next cycle.
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end
                end
            end
            ACCESS: begin
                rdata_d = we_q ? 32'd0 : mem_rdata;
                state_d = RESP;
            end
            RESP: begin
                last_d  = id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Payload registers need no reset: every output that exposes them is gated by state.
    always_ff @(posedge clk) begin
        id_q    <= id_d;
        we_q    <= we_d;
        err_q   <= err_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        rdata_q <= rdata_d;
    end

    always_comb begin
        mem_read  = (state_q == ACCESS) && !we_q;
        mem_write = (state_q == ACCESS) && we_q;
        mem_addr  = (state_q == ACCESS) ? addr_q : 32'd0;
        mem_wdata = (state_q == ACCESS) ? wdata_q : 32'd0;
        ack0      = (state_q == RESP) && !id_q;
        ack1      = (state_q == RESP) && id_q;
        err0      = ack0 && err_q;
        err1      = ack1 && err_q;
        rdata0    = ack0 ? rdata_q : 32'd0;
        rdata1    = ack1 ? rdata_q : 32'd0;
    end

endmodule
